pc_seq: RTL
===========

Name: pc_seq

Overview:
- Parametrised next-generation program counter for the lab core. It sequences instruction fetch and resolves conditional jumps on a register value.
- Jump targets come from the branch LUT, either as absolute addresses or as signed relative offsets.
- Adds call/return through a small hardware return-address stack, plus fetch stall and halt.
- Sits between the decoder/register file (op, do_a), the branch LUT (dout) and instruction memory (PC).

Parameters:
- PC_W, 11, width of PC and of return-stack entries.
- DATA_W, 8, width of do_a and dout.
- RAS_DEPTH, 4, number of return-stack entries; power of 2, at least 2.
- HALT_ADDR_W, 0, reserved; must be 0.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- op  in  3  opcode field from the decoder.
- do_a  in  DATA_W  condition operand (reg1).
- dout  in  DATA_W  LUT output: jump target, or signed offset when rel=1.
- rel  in  1  1 selects relative jump (PC + sign-extended dout); 0 selects absolute (zero-extended dout).
- stall  in  1  hold PC and all state this cycle.
- halt_req  in  1  request transition to HALT.
- PC  out  PC_W  program count.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.
- ras_cnt  out  $clog2(RAS_DEPTH)+1  number of valid return-stack entries.

Behaviour:
- Reset (synchronous, active-high): PC=0, ras_cnt=0, state=RUN, halted=0, fault=0. Stack contents are don't-care.
- Opcodes, held in the package:
  - OP_JZ=3'b100: jump if do_a==0.
  - OP_JNZ=3'b101: jump if do_a!=0.
  - OP_CALL=3'b110: unconditional jump; pushes PC+1.
  - OP_RET=3'b111: PC <= top of stack; pops.
  - All other op values: PC <= PC+1.
- Jump target:
  - rel=0: zero-extended dout.
  - rel=1: PC + sign-extended dout, modulo 2^PC_W.
  - rel applies to JZ, JNZ and CALL.
- Sequential increment wraps from 2^PC_W-1 to 0.
- State RUN, evaluated in priority order:
  1. halt_req: next state HALT, PC holds.
  2. stall: everything holds.
  3. Otherwise the op is executed.
- State HALT: PC, stack and ras_cnt hold; exits only on reset. halted=1.
- State FAULT:
  - Entered from RUN on CALL when ras_cnt==RAS_DEPTH (overflow), or on RET when ras_cnt==0 (underflow).
  - The faulting instruction does not update PC or the stack.
  - fault=1; exits only on reset.
- halt_req has priority over a simultaneous fault condition (HALT wins).
- Latency: the next PC is visible one cycle after op is presented; no bypass.
- The stack is a LIFO register array addressed by ras_cnt-1.
  - CALL writes entry[ras_cnt] and increments ras_cnt in the same edge.
  - RET reads entry[ras_cnt-1] combinationally and decrements.
- CALL with rel=1 computes its offset from the current PC, not PC+1.
- Reset asserted mid-operation (in any state, stalled or not) takes effect at the next edge.

Optional Feature:
- Macro: PC_SEQ_BRCNT_EN.
- When defined:
  - Adds output br_taken_cnt [15:0], cleared on reset.
  - Increments once per executed taken JZ, JNZ, CALL or RET in RUN that is not stalled.
  - Saturates at 16'hFFFF.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package definitions holds:
  - op codes OP_JZ, OP_JNZ, OP_CALL, OP_RET as a 3-bit enum;
  - state enum pc_state_t {RUN, HALT, FAULT};
  - shared width constants.
- One sub-module, pc_ras: the return-address LIFO (push, pop, top, cnt, full, empty).
- Next-PC selection and the FSM stay in pc_seq.

Test Plan:
- Reset, then 5 cycles of op=000: PC 0→5. From PC=2047 with PC_W=11, PC wraps to 0.
- PC=10, op=JZ, rel=0, do_a=0, dout=8'h40: PC=64. Same with do_a=3: PC=11. op=JNZ, do_a=3, rel=1, dout=8'hFE: PC=8.
- PC=20, CALL rel=0 dout=100: PC=100, ras_cnt=1. Then RET: PC=21, ras_cnt=0.
- Five nested CALLs with RAS_DEPTH=4: fifth CALL leaves PC unchanged, fault=1, ras_cnt=4. RET at ras_cnt=0 after reset also gives fault=1 with PC held.
- stall=1 during JZ-taken: PC unchanged. halt_req with simultaneous overflow CALL: halted=1, fault=0. Reset in HALT: PC=0, halted=0.
- With PC_SEQ_BRCNT_EN: 3 taken and 2 not-taken jumps plus 1 stalled taken jump: br_taken_cnt=3.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - default widths for PC, data operands and return stack depth
//   - op_t: the opcodes that change control flow (all others step the PC)
//   - pc_state_t: sequencer run state
package pc_seq_pkg;

    localparam int PC_W_DEF      = 11;
    localparam int DATA_W_DEF    = 8;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_JZ   = 3'b100,
        OP_JNZ  = 3'b101,
        OP_CALL = 3'b110,
        OP_RET  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address LIFO for CALL/RET.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears cnt only)
//   push        - write push_data at entry[cnt], cnt+1
//   push_data   - return address to store
//   pop         - cnt-1 (top is read combinationally beforehand)
//   top         - entry[cnt-1]
//   cnt         - number of valid entries (0..DEPTH)
//   full, empty - cnt==DEPTH, cnt==0
// The caller must never push when full or pop when empty.
module pc_ras #(
    parameter int PC_W  = 11,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [PC_W-1:0]        push_data,
    input  logic                   pop,
    output logic [PC_W-1:0]        top,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [PC_W-1:0]  entry [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // DEPTH is a power of two, so the low bits of cnt address the array
    // directly; at cnt==DEPTH they alias entry 0, but full blocks the push.
    assign wr_idx = cnt_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);

    assign top   = entry[rd_idx];
    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (push) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // NOTE: the entry array is deliberately left out of reset; cnt alone
    // defines which entries are valid, so clearing storage buys nothing.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            entry[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program counter with conditional/relative jumps, CALL/RET through a
// hardware return stack, fetch stall, halt and stack-fault trapping.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   op           - opcode (JZ/JNZ/CALL/RET; anything else steps PC)
//   do_a         - condition operand, tested against zero
//   dout         - jump target (rel=0) or signed offset from PC (rel=1)
//   rel          - select relative jump for JZ, JNZ and CALL
//   stall        - hold all state this cycle
//   halt_req     - enter HALT (wins over stall and stack faults)
//   PC           - current program count
//   halted/fault - in HALT / in FAULT (both sticky until reset)
//   ras_cnt      - valid return-stack entries
//   br_taken_cnt - saturating taken-branch count (only with PC_SEQ_BRCNT_EN)
// Optional feature macro: PC_SEQ_BRCNT_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RAS_DEPTH   = RAS_DEPTH_DEF,
    parameter int HALT_ADDR_W = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 op,
    input  logic [DATA_W-1:0]          do_a,
    input  logic [DATA_W-1:0]          dout,
    input  logic                       rel,
    input  logic                       stall,
    input  logic                       halt_req,
    output logic [PC_W-1:0]            PC,
    output logic                       halted,
    output logic                       fault,
    output logic [$clog2(RAS_DEPTH):0] ras_cnt
`ifdef PC_SEQ_BRCNT_EN
    ,
    output logic [15:0]                br_taken_cnt
`endif
);

    if (HALT_ADDR_W != 0) begin : g_halt_addr_w_check
        $error("pc_seq: HALT_ADDR_W is reserved and must be 0");
    end

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, target, ras_top;
    logic            ras_full, ras_empty;
    logic            exec, stack_fault, push, pop, taken;

    assign pc_inc = pc_q + PC_W'(1);
    // Casting the signed operand to PC_W sign-extends it; the add wraps.
    assign target = rel ? pc_q + PC_W'($signed(dout)) : PC_W'(dout);

    // An op executes only in RUN when neither halt_req nor stall claims the cycle.
    assign exec        = (state_q == RUN) && !halt_req && !stall;
    assign stack_fault = ((op == OP_CALL) && ras_full) || ((op == OP_RET) && ras_empty);
    assign push        = exec && (op == OP_CALL) && !ras_full;
    assign pop         = exec && (op == OP_RET) && !ras_empty;
    assign taken       = exec && !stack_fault &&
                         (((op == OP_JZ)  && (do_a == '0)) ||
                          ((op == OP_JNZ) && (do_a != '0)) ||
                          (op == OP_CALL) || (op == OP_RET));

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pc_inc),
        .pop       (pop),
        .top       (ras_top),
        .cnt       (ras_cnt),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // State register (PC travels with the FSM state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and next-PC logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (!stall && stack_fault) begin
                    state_d = FAULT;
                end
            end
            default: state_d = state_q;
        endcase

        if (exec && !stack_fault) begin
            case (op)
                OP_JZ:   pc_d = (do_a == '0) ? target : pc_inc;
                OP_JNZ:  pc_d = (do_a != '0) ? target : pc_inc;
                OP_CALL: pc_d = target;
                OP_RET:  pc_d = ras_top;
                default: pc_d = pc_inc;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        PC     = pc_q;
        halted = (state_q == HALT);
        fault  = (state_q == FAULT);
    end

`ifdef PC_SEQ_BRCNT_EN
    logic [15:0] br_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q <= '0;
        end else if (taken && (br_cnt_q != 16'hFFFF)) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`else
    logic unused_taken;
    assign unused_taken = taken;
`endif

endmodule
